// File: rtl/alarma_pkg.sv
// Shared definitions for the multi-channel alarm clock.
//   - channel state encoding
//   - time-of-day limits
//   - hh:mm wrap-around addition used when pushing a snooze target forward
package alarma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZED  = 2'd3
    } state_t;

    localparam int MINUTES_PER_HOUR = 60;
    localparam int HOURS_PER_DAY    = 24;

    // Reset / "no time stored" marker values.
    localparam logic [5:0] MIN_INVALID  = 6'h3F;
    localparam logic [4:0] HOUR_INVALID = 5'h1F;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
    } hm_t;

    // Adds delta minutes (0..59) to a valid time. A single carry is enough
    // because both operands are below 60; the hour wraps 23 -> 0.
    function automatic hm_t wrap_add(input hm_t t, input logic [5:0] delta);
        logic [6:0] m_sum;
        hm_t        r;
        m_sum = {1'b0, t.m} + {1'b0, delta};
        r     = t;
        if (m_sum >= 7'(MINUTES_PER_HOUR)) begin
            r.m = 6'(m_sum - 7'(MINUTES_PER_HOUR));
            if (t.h >= 5'(HOURS_PER_DAY - 1)) begin
                r.h = 5'd0;
            end else begin
                r.h = t.h + 5'd1;
            end
        end else begin
            r.m = m_sum[5:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/alarma_canal.sv
// One alarm channel: stores set time, target time, snooze count and state.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   tick                  - minute changed this cycle (from top)
//   minute_counter/ore_counter - current time
//   load                  - load strobe already decoded for this channel
//   minute_setare/ore_setare/enable_setare - values written by load
//   stop, snooze          - dismiss / snooze request for this channel
//   led                   - registered ringing indicator
//   armed                 - registered "state is not IDLE"
//   led_next              - value led takes on the next edge (for any_led)
module alarma_canal
    import alarma_pkg::*;
#(
    parameter int SNOOZE_MIN = 10,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [5:0] minute_counter,
    input  logic [4:0] ore_counter,
    input  logic       load,
    input  logic [5:0] minute_setare,
    input  logic [4:0] ore_setare,
    input  logic       enable_setare,
    input  logic       stop,
    input  logic       snooze,
    output logic       led,
    output logic       armed,
    output logic       led_next
);

    state_t     state_reg, state_next;
    hm_t        set_reg, set_next;
    hm_t        tgt_reg, tgt_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       led_reg;
    logic       armed_reg;
    logic       setting_valid;
    logic       time_match;
    logic       give_up;
    hm_t        tgt_snoozed;

    assign setting_valid = (minute_setare < 6'(MINUTES_PER_HOUR)) &&
                           (ore_setare < 5'(HOURS_PER_DAY));
    assign time_match    = (minute_counter == tgt_reg.m) && (ore_counter == tgt_reg.h);
    assign give_up       = (cnt_reg == 4'(MAX_SNOOZE));
    assign tgt_snoozed   = wrap_add(tgt_reg, 6'(SNOOZE_MIN));

    always_comb begin
        state_next = state_reg;
        set_next   = set_reg;
        tgt_next   = tgt_reg;
        cnt_next   = cnt_reg;

        if (load) begin
            set_next   = '{h: ore_setare, m: minute_setare};
            tgt_next   = '{h: ore_setare, m: minute_setare};
            cnt_next   = 4'd0;
            state_next = (enable_setare && setting_valid) ? ST_ARMED : ST_IDLE;
        end else if (stop && (state_reg == ST_RINGING || state_reg == ST_SNOOZED)) begin
            state_next = ST_ARMED;
            tgt_next   = set_reg;
            cnt_next   = 4'd0;
        end else if ((snooze || tick) && state_reg == ST_RINGING) begin
            // Explicit snooze or auto-snooze; once the budget is spent the
            // channel re-arms for the original time instead.
            if (give_up) begin
                state_next = ST_ARMED;
                tgt_next   = set_reg;
                cnt_next   = 4'd0;
            end else begin
                state_next = ST_SNOOZED;
                tgt_next   = tgt_snoozed;
                cnt_next   = cnt_reg + 4'd1;
            end
        end else if (tick && time_match &&
                     (state_reg == ST_ARMED || state_reg == ST_SNOOZED)) begin
            state_next = ST_RINGING;
        end
    end

    assign led_next = (state_next == ST_RINGING);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            set_reg   <= '{h: HOUR_INVALID, m: MIN_INVALID};
            tgt_reg   <= '{h: HOUR_INVALID, m: MIN_INVALID};
            cnt_reg   <= 4'd0;
            led_reg   <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            set_reg   <= set_next;
            tgt_reg   <= tgt_next;
            cnt_reg   <= cnt_next;
            led_reg   <= led_next;
            armed_reg <= (state_next != ST_IDLE);
        end
    end

    assign led   = led_reg;
    assign armed = armed_reg;

endmodule

// File: rtl/alarma_multi.sv
// Multi-channel alarm clock top.
// Ports:
//   clock, reset               - clock and synchronous active-high reset
//   minute_counter, ore_counter - current time (mm 0..59, hh 0..23)
//   load, load_ch              - one-cycle strobe writing a setting to load_ch
//   minute_setare, ore_setare, enable_setare - setting written by load
//   stop, snooze               - per-channel dismiss / snooze (level)
//   led, armed                 - per-channel registered status
//   any_led                    - registered OR of all led bits
module alarma_multi
    import alarma_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SNOOZE_MIN = 10,
    parameter int MAX_SNOOZE = 3,
    localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [5:0]      minute_counter,
    input  logic [4:0]      ore_counter,
    input  logic            load,
    input  logic [CW-1:0]   load_ch,
    input  logic [5:0]      minute_setare,
    input  logic [4:0]      ore_setare,
    input  logic            enable_setare,
    input  logic [N_CH-1:0] stop,
    input  logic [N_CH-1:0] snooze,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] armed,
    output logic            any_led
);

    logic [5:0]      prev_minute_reg;
    logic            tick;
    logic [N_CH-1:0] led_next_vec;
    logic            any_led_reg;

    // Any change of the minute value counts as a tick; the 6'h3F reset value
    // makes the first cycle after reset a tick as well (harmless: all IDLE).
    assign tick = (minute_counter != prev_minute_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_minute_reg <= MIN_INVALID;
            any_led_reg     <= 1'b0;
        end else begin
            prev_minute_reg <= minute_counter;
            // Built from the channels' next led values so any_led rises on
            // the same edge as the led bits themselves.
            any_led_reg     <= |led_next_vec;
        end
    end

    assign any_led = any_led_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_canal
            alarma_canal #(
                .SNOOZE_MIN (SNOOZE_MIN),
                .MAX_SNOOZE (MAX_SNOOZE)
            ) u_canal (
                .clock          (clock),
                .reset          (reset),
                .tick           (tick),
                .minute_counter (minute_counter),
                .ore_counter    (ore_counter),
                .load           (load && (load_ch == CW'(gi))),
                .minute_setare  (minute_setare),
                .ore_setare     (ore_setare),
                .enable_setare  (enable_setare),
                .stop           (stop[gi]),
                .snooze         (snooze[gi]),
                .led            (led[gi]),
                .armed          (armed[gi]),
                .led_next       (led_next_vec[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_alarma_multi.sv
module tb_alarma_multi;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] minute_counter;
    logic [4:0] ore_counter;
    logic       load;
    logic [1:0] load_ch;
    logic [5:0] minute_setare;
    logic [4:0] ore_setare;
    logic       enable_setare;
    logic [3:0] stop;
    logic [3:0] snooze;
    logic [3:0] led;
    logic [3:0] armed;
    logic       any_led;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    alarma_multi #(.N_CH(4), .SNOOZE_MIN(10), .MAX_SNOOZE(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .minute_counter (minute_counter),
        .ore_counter    (ore_counter),
        .load           (load),
        .load_ch        (load_ch),
        .minute_setare  (minute_setare),
        .ore_setare     (ore_setare),
        .enable_setare  (enable_setare),
        .stop           (stop),
        .snooze         (snooze),
        .led            (led),
        .armed          (armed),
        .any_led        (any_led)
    );

    typedef struct {
        logic       ld;
        logic [1:0] ch;
        logic [5:0] ms;
        logic [4:0] hs;
        logic       en;
        logic [3:0] st;
        logic [3:0] sn;
        logic [4:0] h;
        logic [5:0] m;
        logic [3:0] e_led;
        logic [3:0] e_armed;
        logic       e_any;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic [1:0] ch, input int ms, input int hs,
                                input logic en, input logic [3:0] st, input logic [3:0] sn,
                                input int h, input int m, input logic [3:0] e_led,
                                input logic [3:0] e_armed, input logic e_any);
        vec_t v;
        v.ld = ld; v.ch = ch; v.ms = 6'(ms); v.hs = 5'(hs); v.en = en;
        v.st = st; v.sn = sn; v.h = 5'(h); v.m = 6'(m);
        v.e_led = e_led; v.e_armed = e_armed; v.e_any = e_any;
        return v;
    endfunction

    task automatic check_outputs(input string name, input logic [3:0] e_led,
                                 input logic [3:0] e_armed, input logic e_any);
        tests_run++;
        if (led !== e_led || armed !== e_armed || any_led !== e_any) begin
            tests_failed++;
            $display("FAIL %s: led=%b armed=%b any_led=%b, required led=%b armed=%b any_led=%b",
                     name, led, armed, any_led, e_led, e_armed, e_any);
        end else begin
            $display("[TB] ok %s: led=%b armed=%b any_led=%b", name, led, armed, any_led);
        end
    endtask

    // One cycle: drive inputs, take one rising edge, compare 1 time unit later.
    task automatic run_vec(input vec_t v, input string name);
        load           = v.ld;
        load_ch        = v.ch;
        minute_setare  = v.ms;
        ore_setare     = v.hs;
        enable_setare  = v.en;
        stop           = v.st;
        snooze         = v.sn;
        ore_counter    = v.h;
        minute_counter = v.m;
        @(posedge clock);
        #1;
        check_outputs(name, v.e_led, v.e_armed, v.e_any);
    endtask

    vec_t tbl[19];
    vec_t seq35[12];

    initial begin
        // ld ch ms hs en stop snooze | hh mm | led armed any
        tbl[0]  = mk(1, 0, 30,  7, 1, 4'h0, 4'h0,  7, 29, 4'h0, 4'h1, 0); // load ch0 07:30
        tbl[1]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  7, 29, 4'h0, 4'h1, 0);
        tbl[2]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  7, 30, 4'h1, 4'h1, 1); // ring ch0
        tbl[3]  = mk(0, 0,  0,  0, 0, 4'h1, 4'h0,  7, 30, 4'h0, 4'h1, 0); // stop ch0
        tbl[4]  = mk(1, 1, 55, 23, 1, 4'h0, 4'h0,  7, 30, 4'h0, 4'h3, 0); // load ch1 23:55
        tbl[5]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0, 23, 55, 4'h2, 4'h3, 1); // ring ch1
        tbl[6]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h2, 23, 55, 4'h0, 4'h3, 0); // snooze ch1
        tbl[7]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  0,  4, 4'h0, 4'h3, 0);
        tbl[8]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  0,  5, 4'h2, 4'h3, 1); // wrapped 00:05
        tbl[9]  = mk(0, 0,  0,  0, 0, 4'h2, 4'h0,  0,  5, 4'h0, 4'h3, 0);
        tbl[10] = mk(1, 3,  0, 10, 1, 4'h0, 4'h0,  0,  5, 4'h0, 4'hB, 0); // load ch3 10:00
        tbl[11] = mk(0, 0,  0,  0, 0, 4'h0, 4'h0, 10,  0, 4'h8, 4'hB, 1);
        tbl[12] = mk(1, 3, 15, 11, 1, 4'h8, 4'h0, 10,  0, 4'h0, 4'hB, 0); // load beats stop
        tbl[13] = mk(0, 0,  0,  0, 0, 4'h0, 4'h0, 11, 15, 4'h8, 4'hB, 1); // new time rings
        tbl[14] = mk(0, 0,  0,  0, 0, 4'h8, 4'h0, 11, 15, 4'h0, 4'hB, 0);
        tbl[15] = mk(1, 0, 60, 12, 1, 4'h0, 4'h0, 11, 15, 4'h0, 4'hA, 0); // minute 60 -> IDLE
        tbl[16] = mk(1, 0,  0, 12, 1, 4'h0, 4'h0, 11, 15, 4'h0, 4'hB, 0);
        tbl[17] = mk(1, 1,  0, 12, 1, 4'h0, 4'h0, 11, 15, 4'h0, 4'hB, 0);
        tbl[18] = mk(0, 0,  0,  0, 0, 4'h0, 4'h0, 12,  0, 4'h3, 4'hB, 1); // ch0+ch1 together

        // Auto-snooze budget on ch2 set to 08:00.
        seq35[0]  = mk(1, 2,  0,  8, 1, 4'h0, 4'h0,  7, 58, 4'h0, 4'h4, 0);
        seq35[1]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  7, 59, 4'h0, 4'h4, 0);
        seq35[2]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8,  0, 4'h4, 4'h4, 1);
        seq35[3]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8,  1, 4'h0, 4'h4, 0);
        seq35[4]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8, 10, 4'h4, 4'h4, 1);
        seq35[5]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8, 11, 4'h0, 4'h4, 0);
        seq35[6]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8, 20, 4'h4, 4'h4, 1);
        seq35[7]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8, 21, 4'h0, 4'h4, 0);
        seq35[8]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8, 30, 4'h4, 4'h4, 1);
        seq35[9]  = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8, 31, 4'h0, 4'h4, 0); // gives up
        seq35[10] = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8, 40, 4'h0, 4'h4, 0); // no ring
        seq35[11] = mk(0, 0,  0,  0, 0, 4'h0, 4'h0,  8,  0, 4'h4, 4'h4, 1); // target restored

        // Reset with quiet inputs.
        reset = 1'b1;
        load = 1'b0; load_ch = 2'd0; minute_setare = 6'd0; ore_setare = 5'd0;
        enable_setare = 1'b0; stop = 4'h0; snooze = 4'h0;
        minute_counter = 6'd0; ore_counter = 5'd7;
        repeat (3) @(posedge clock);
        #1;
        check_outputs("reset_state", 4'h0, 4'h0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_vec(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // ch0 and ch1 are ringing now; reset must clear everything in one edge.
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_outputs("reset_mid_ring", 4'h0, 4'h0, 1'b0);
        reset = 1'b0;
        run_vec(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 11, 59, 4'h0, 4'h0, 0), "post_reset_1159");
        run_vec(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 12,  0, 4'h0, 4'h0, 0), "post_reset_1200");

        for (int i = 0; i < 12; i++) begin
            run_vec(seq35[i], $sformatf("autosnooze[%0d]", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
